// File: rtl/sd_lader_pkg.sv
// Shared types and constants for the SD block loader.
package sd_lader_pkg;
  localparam int unsigned ADR_W   = 32;
  localparam int unsigned DATEN_W = 32;
  localparam int unsigned ANZ_W   = 16;
  localparam int unsigned TO_W    = 24;

  localparam logic [TO_W-1:0] TIMEOUT_ZYKLEN_DEFAULT = 24'd10_000_000;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WARTE_FREI  = 3'd1,
    ANFRAGE     = 3'd2,
    WARTE_DATEN = 3'd3,
    SCHREIBEN   = 3'd4,
    ENDE        = 3'd5
  } zustand_t;
endpackage

// File: rtl/sd_lader_timeout.sv
// Loadable down-counter flagging when a reader wait exceeds its cycle budget.
module sd_lader_timeout
  import sd_lader_pkg::*;
(
  input  logic            Clock,
  input  logic            Reset,
  input  logic [TO_W-1:0] start_wert,
  input  logic            laden,
  input  logic            zaehlen,
  output logic            abgelaufen_c
);
  logic [TO_W-1:0] zaehler;

  always_ff @(posedge Clock) begin
    if (Reset)
      zaehler <= '0;
    else if (laden)
      zaehler <= start_wert;
    else if (zaehlen && (zaehler != '0))
      zaehler <= zaehler - TO_W'(1);
  end

  assign abgelaufen_c = zaehlen && (zaehler == '0);
endmodule

// File: rtl/sd_block_lader.sv
// Copies Anzahl words from the SD reader into memory, one read request per word.
// Optional reader-wait timeout enabled by defining SD_LADER_TIMEOUT_EN.
module sd_block_lader
  import sd_lader_pkg::*;
#(
  parameter logic [TO_W-1:0] TIMEOUT_ZYKLEN = TIMEOUT_ZYKLEN_DEFAULT
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic [ADR_W-1:0]   QuellAdresse,
  input  logic [ADR_W-1:0]   ZielAdresse,
  input  logic [ANZ_W-1:0]   Anzahl,
  output logic               Busy,
  output logic               Fertig,
  output logic               Fehler,
  output logic [ADR_W-1:0]   SdAdresse,
  output logic               SdLesen,
  input  logic [DATEN_W-1:0] SdDaten,
  input  logic               SdFertig,
  input  logic               SdBusy,
  output logic [ADR_W-1:0]   SpeicherAdresse,
  output logic [DATEN_W-1:0] SpeicherDaten,
  output logic               SpeicherSchreiben,
  input  logic               SpeicherBereit
);
  zustand_t         zustand;
  logic [ADR_W-1:0] quelle;
  logic [ADR_W-1:0] ziel;
  logic [ANZ_W-1:0] rest;
  logic             abbruch_c;

`ifdef SD_LADER_TIMEOUT_EN
  // Both wait states are always separated by a non-waiting state, so reloading
  // outside them restarts the budget on every state change.
  logic warten_c;
  assign warten_c = (zustand == WARTE_FREI) || (zustand == WARTE_DATEN);

  sd_lader_timeout u_timeout (
    .Clock        (Clock),
    .Reset        (Reset),
    .start_wert   (TIMEOUT_ZYKLEN),
    .laden        (!warten_c),
    .zaehlen      (warten_c),
    .abgelaufen_c (abbruch_c)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_ZYKLEN;
  assign abbruch_c      = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      zustand           <= IDLE;
      quelle            <= '0;
      ziel              <= '0;
      rest              <= '0;
      Busy              <= 1'b0;
      Fertig            <= 1'b0;
      Fehler            <= 1'b0;
      SdAdresse         <= '0;
      SdLesen           <= 1'b0;
      SpeicherAdresse   <= '0;
      SpeicherDaten     <= '0;
      SpeicherSchreiben <= 1'b0;
    end else begin
      SdLesen <= 1'b0;
      Fertig  <= 1'b0;
      case (zustand)
        IDLE: begin
          if (Start) begin
            quelle  <= QuellAdresse;
            ziel    <= ZielAdresse;
            rest    <= Anzahl;
            Busy    <= 1'b1;
            Fehler  <= 1'b0;
            zustand <= (Anzahl == '0) ? ENDE : WARTE_FREI;
          end
        end
        // The reader keeps finishing its sector after Fertig; it must be idle first.
        WARTE_FREI: begin
          if (abbruch_c) begin
            Fehler  <= 1'b1;
            zustand <= ENDE;
          end else if (!SdBusy && !SdFertig) begin
            SdAdresse <= quelle;
            SdLesen   <= 1'b1;
            zustand   <= ANFRAGE;
          end
        end
        ANFRAGE: zustand <= WARTE_DATEN;
        WARTE_DATEN: begin
          if (SdFertig) begin
            SpeicherDaten     <= SdDaten;
            SpeicherAdresse   <= ziel;
            SpeicherSchreiben <= 1'b1;
            zustand           <= SCHREIBEN;
          end else if (abbruch_c) begin
            Fehler  <= 1'b1;
            zustand <= ENDE;
          end
        end
        SCHREIBEN: begin
          if (SpeicherBereit) begin
            SpeicherSchreiben <= 1'b0;
            quelle            <= quelle + ADR_W'(1);
            ziel              <= ziel + ADR_W'(1);
            rest              <= rest - ANZ_W'(1);
            zustand           <= (rest == ANZ_W'(1)) ? ENDE : WARTE_FREI;
          end
        end
        ENDE: begin
          Fertig  <= 1'b1;
          Busy    <= 1'b0;
          zustand <= IDLE;
        end
        default: zustand <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_block_lader.sv
// Scoreboard bench for sd_block_lader with behavioural SD reader and memory models.
module tb_sd_block_lader;
  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [31:0] QuellAdresse = '0;
  logic [31:0] ZielAdresse = '0;
  logic [15:0] Anzahl = '0;
  logic        Busy, Fertig, Fehler, SdLesen, SpeicherSchreiben;
  logic [31:0] SdAdresse, SpeicherAdresse, SpeicherDaten;
  logic [31:0] SdDaten = '0;
  logic        SdFertig = 1'b0;
  logic        SdBusy = 1'b0;
  logic        SpeicherBereit = 1'b0;

  sd_block_lader #(.TIMEOUT_ZYKLEN(24'd50)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start),
    .QuellAdresse(QuellAdresse), .ZielAdresse(ZielAdresse), .Anzahl(Anzahl),
    .Busy(Busy), .Fertig(Fertig), .Fehler(Fehler),
    .SdAdresse(SdAdresse), .SdLesen(SdLesen), .SdDaten(SdDaten),
    .SdFertig(SdFertig), .SdBusy(SdBusy),
    .SpeicherAdresse(SpeicherAdresse), .SpeicherDaten(SpeicherDaten),
    .SpeicherSchreiben(SpeicherSchreiben), .SpeicherBereit(SpeicherBereit)
  );

  always #5 Clock = ~Clock;

  int fehler_n = 0;
  int checks_n = 0;

  logic [31:0] q_sd[$];
  logic [63:0] q_wr[$];
  logic        q_done[$];

  // SD card contents as a pure function of the word address
  function automatic logic [31:0] sd_wort(input logic [31:0] a);
    return a * 32'h9E37_79B1 ^ 32'h5A5A_0F0F;
  endfunction

  task automatic pruefe(input string name, input logic [127:0] ist, input logic [127:0] soll);
    checks_n++;
    if (ist !== soll) begin
      fehler_n++;
      $display("FAIL %s: actual=%0h required=%0h", name, ist, soll);
    end
  endtask

  task automatic melde(input string name);
    checks_n++;
    fehler_n++;
    $display("FAIL %s: event occurred, none required", name);
  endtask

  // Reader model: answers after a random delay, then stays busy busy_nach cycles.
  int          lese_max = 4;
  int          busy_nach = 2;
  bit          stumm = 0;
  bit          pend = 0;
  int          rd_cnt = 0;
  int          busy_cnt = 0;
  logic [31:0] rd_adr = '0;

  always @(negedge Clock) begin
    if (Reset) begin
      pend = 0; busy_cnt = 0; SdBusy = 0; SdFertig = 0;
    end else begin
      SdFertig = 0;
      if (pend) begin
        if (rd_cnt == 0 && !stumm) begin
          SdFertig = 1; SdDaten = sd_wort(rd_adr); pend = 0; busy_cnt = busy_nach;
        end else if (rd_cnt > 0) rd_cnt--;
      end else if (busy_cnt > 0) busy_cnt--;
      if (SdLesen) begin
        pend = 1; rd_adr = SdAdresse; rd_cnt = $urandom_range(lese_max, 1);
      end
      SdBusy = pend || (busy_cnt > 0) || SdFertig;
    end
  end

  // Memory model: random acceptance, or a fixed number of refusals per write
  int bp_n = 0;
  int bp_w = 0;
  int bp_soll = 0;

  always @(negedge Clock) begin
    if (bp_n > 0) begin
      if (SpeicherSchreiben && bp_w < bp_n) begin SpeicherBereit = 0; bp_w++; end
      else if (SpeicherSchreiben) begin SpeicherBereit = 1; bp_w = 0; end
      else begin SpeicherBereit = 0; bp_w = 0; end
    end else
      SpeicherBereit = ($urandom_range(3, 0) != 0);
  end

  // Monitor: sample just after each active edge and score against the queues
  logic        p_lesen = 0, p_schr = 0, p_fertig = 0;
  logic [31:0] p_adr = '0, p_dat = '0;
  int          p_len = 0;

  always @(posedge Clock) begin
    #1;
    if (Reset) begin
      p_lesen = 0; p_schr = 0; p_fertig = 0; p_len = 0;
    end else begin
      if (SdLesen) begin
        pruefe("lesen_protokoll", 128'({SdBusy, SpeicherSchreiben, p_lesen}), 128'(0));
        if (q_sd.size() == 0) melde("sdlesen_unerwartet");
        else pruefe("sd_adresse", 128'(SdAdresse), 128'(q_sd.pop_front()));
      end
      if (p_schr) begin
        if (SpeicherBereit) begin
          pruefe("schreiben_faellt", 128'(SpeicherSchreiben), 128'(0));
          if (q_wr.size() == 0) melde("schreiben_unerwartet");
          else pruefe("schreibzugriff", 128'({p_adr, p_dat}), 128'(q_wr.pop_front()));
          if (bp_soll != 0) pruefe("schreib_dauer", 128'(p_len), 128'(bp_soll));
        end else
          pruefe("speicher_stabil", 128'({SpeicherSchreiben, SpeicherAdresse, SpeicherDaten}),
                 128'({1'b1, p_adr, p_dat}));
      end
      if (Fertig) begin
        if (q_done.size() == 0) melde("fertig_unerwartet");
        else pruefe("fertig_status", 128'({p_fertig, Busy, Fehler}), 128'({2'b00, q_done.pop_front()}));
      end
      p_len = SpeicherSchreiben ? p_len + 1 : 0;
      p_lesen = SdLesen; p_schr = SpeicherSchreiben; p_fertig = Fertig;
      p_adr = SpeicherAdresse; p_dat = SpeicherDaten;
    end
  end

  task automatic starte(input logic [31:0] q, input logic [31:0] z, input int n, input bit fehl);
    for (int i = 0; i < n; i++) begin
      q_sd.push_back(q + 32'(i));
      q_wr.push_back({z + 32'(i), sd_wort(q + 32'(i))});
    end
    q_done.push_back(fehl);
    @(negedge Clock);
    QuellAdresse = q; ZielAdresse = z; Anzahl = 16'(n); Start = 1;
    @(negedge Clock);
    Start = 0; QuellAdresse = $urandom; ZielAdresse = $urandom; Anzahl = 16'($urandom);
  endtask

  task automatic warte_fertig(input int limit);
    int k = 0;
    while (q_done.size() != 0 && k < limit) begin @(negedge Clock); k++; end
    if (q_done.size() != 0) begin
      melde("zeitlimit_fertig");
      q_done.delete(); q_sd.delete(); q_wr.delete();
    end
    repeat (3) @(negedge Clock);
  endtask

  task automatic warte_lesen(input int anzahl);
    int k = 0;
    int gesehen = 0;
    while (gesehen < anzahl && k < 500) begin
      @(negedge Clock); k++;
      if (SdLesen) gesehen++;
    end
    if (gesehen < anzahl) melde("zeitlimit_sdlesen");
  endtask

  task automatic alle_null(input string name);
    pruefe(name, 128'({Busy, Fertig, Fehler, SdLesen, SpeicherSchreiben,
                        SdAdresse, SpeicherAdresse, SpeicherDaten}), 128'(0));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge Clock);
    @(posedge Clock); #1;
    alle_null("reset_ausgaenge");
    @(negedge Clock); Reset = 0;
    repeat (2) @(negedge Clock);

    // Single word
    starte(32'h10, 32'h200, 1, 1'b0);
    warte_fertig(300);
    pruefe("einzel_daten_ref", 128'(sd_wort(32'h10)), 128'(32'hDEADBEEF ^ 32'hDEADBEEF ^ sd_wort(32'h10)));

    // Burst crossing a sector boundary with a long post-read busy phase
    busy_nach = 20;
    starte(32'h7E, 32'h1000, 4, 1'b0);
    warte_fertig(1000);
    busy_nach = 2;

    // Zero-length transfer: Busy next edge, Fertig two edges after Start
    q_done.push_back(1'b0);
    @(negedge Clock);
    QuellAdresse = 32'h55; ZielAdresse = 32'h66; Anzahl = 16'd0; Start = 1;
    @(posedge Clock); #1;
    pruefe("anzahl0_busy", 128'({Busy, Fertig}), 128'(2'b10));
    @(negedge Clock); Start = 0;
    @(posedge Clock); #1;
    pruefe("anzahl0_fertig", 128'({Fertig, Busy}), 128'(2'b10));
    warte_fertig(20);

    // Memory back-pressure: five refusals per write
    bp_n = 5; bp_soll = 6;
    starte(32'h300, 32'h4000, 2, 1'b0);
    warte_fertig(500);
    bp_n = 0; bp_soll = 0;

    // Reset while waiting for word 2 of 3
    starte(32'h900, 32'h5000, 3, 1'b0);
    warte_lesen(2);
    @(negedge Clock);
    q_sd.delete(); q_wr.delete(); q_done.delete();
    Reset = 1;
    @(posedge Clock); #1;
    alle_null("reset_mitten");
    repeat (2) @(negedge Clock);
    Reset = 0;
    repeat (2) @(negedge Clock);

    // Fresh transfer; a second Start mid-transfer must be ignored
    starte(32'hA00, 32'h6000, 3, 1'b0);
    warte_lesen(1);
    @(negedge Clock);
    QuellAdresse = 32'hBAD0; ZielAdresse = 32'hBAD1; Anzahl = 16'd9; Start = 1;
    @(negedge Clock); Start = 0;
    warte_fertig(500);

    // Randomized transfers, including address wrap-around
    for (int t = 0; t < 10; t++) begin
      logic [31:0] q, z;
      q = ($urandom_range(2, 0) == 0) ? 32'hFFFF_FFFE : $urandom;
      z = ($urandom_range(2, 0) == 0) ? 32'hFFFF_FFFD : $urandom;
      busy_nach = $urandom_range(4, 0);
      starte(q, z, $urandom_range(6, 0), 1'b0);
      warte_fertig(800);
    end
    busy_nach = 2;

`ifdef SD_LADER_TIMEOUT_EN
    // Reader never answers: abort with Fehler and no memory write
    begin
      int k = 0;
      int seit = -1;
      stumm = 1;
      starte(32'hC00, 32'h7000, 2, 1'b1);
      q_sd.delete();
      q_sd.push_back(32'hC00);
      q_wr.delete();
      while (!Fertig && k < 300) begin
        @(negedge Clock); k++;
        if (SdLesen) seit = 0; else if (seit >= 0) seit++;
      end
      checks_n++;
      if (!Fertig || seit < 45 || seit > 60) begin
        fehler_n++;
        $display("FAIL timeout_latenz: actual=%0d cycles required=45..60", seit);
      end
      repeat (3) @(negedge Clock);
      pruefe("timeout_fehler_gehalten", 128'({Fehler, Busy}), 128'(2'b10));
      Reset = 1; stumm = 0;
      repeat (2) @(negedge Clock);
      Reset = 0;
      repeat (2) @(negedge Clock);
    end
`endif

    pruefe("rest_sd_queue", 128'(q_sd.size()), 128'(0));
    pruefe("rest_wr_queue", 128'(q_wr.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", fehler_n, checks_n);
    $finish;
  end
endmodule
